// File: rtl/game_pkg.sv
// Shared definitions for the guessing game: hint codes, judge FSM states,
// LFSR taps and the attempt-counter width.
package game_pkg;

    localparam int          ATT_W     = 4;
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;  // taps 8,6,5,4

    typedef enum logic [1:0] {
        HINT_NONE = 2'b00,
        HINT_LOW  = 2'b01,
        HINT_HIGH = 2'b10,
        HINT_OK   = 2'b11
    } hint_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUESS = 2'd1,
        S_WIN   = 2'd2,
        S_LOSE  = 2'd3
    } judge_state_t;

    // One Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// 8-bit free-running Fibonacci LFSR with seed, synchronous active-low reset
// and enable. A zero seed is replaced so the register can never lock up.
module game_lfsr
    import game_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       master_reset,
    input  logic       en,
    output logic [7:0] value
);

    localparam logic [7:0] SEED_SAFE = (SEED == 8'h00) ? 8'h01 : SEED;

    always_ff @(posedge clk) begin
        if (!master_reset)
            value <= SEED_SAFE;
        else if (en)
            value <= lfsr_step(value);
    end

endmodule

// File: rtl/guess_judge.sv
// Judges player guesses against an LFSR-drawn target, counts attempts and
// raises win/lose/over for the game controller and display.
module guess_judge
    import game_pkg::*;
#(
    parameter int         W         = 4,
    parameter int         MAX_TRIES = 5,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic             clk,
    input  logic             master_reset,
    input  logic             state,
    input  logic             submit,
    input  logic [W-1:0]     guess,
    output logic [W-1:0]     target,
    output logic [1:0]       hint,
    output logic [ATT_W-1:0] attempts_left,
    output logic             win,
    output logic             lose,
    output logic             over
);

    localparam logic [ATT_W-1:0] MAX_ATT = ATT_W'(MAX_TRIES);

    logic       state_s1, state_s2;
    logic       sub_s1, sub_s2, sub_s3;
    logic       press_pulse;
    logic [7:0] lfsr_val;

    judge_state_t     fsm, fsm_n;
    hint_t            hint_q, hint_n;
    logic [W-1:0]     target_q, target_n;
    logic [ATT_W-1:0] att_q, att_n;
    logic             win_q, win_n, lose_q, lose_n;

    game_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk          (clk),
        .master_reset (master_reset),
        .en           (1'b1),
        .value        (lfsr_val)
    );

    // Two-flop synchronisers; submit idles high (button released).
    always_ff @(posedge clk) begin
        if (!master_reset) begin
            state_s1 <= 1'b0;
            state_s2 <= 1'b0;
            sub_s1   <= 1'b1;
            sub_s2   <= 1'b1;
            sub_s3   <= 1'b1;
        end else begin
            state_s1 <= state;
            state_s2 <= state_s1;
            sub_s1   <= submit;
            sub_s2   <= sub_s1;
            sub_s3   <= sub_s2;
        end
    end

    assign press_pulse = sub_s3 & ~sub_s2;

    always_ff @(posedge clk) begin
        if (!master_reset) begin
            fsm      <= S_IDLE;
            hint_q   <= HINT_NONE;
            target_q <= '0;
            att_q    <= MAX_ATT;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
        end else begin
            fsm      <= fsm_n;
            hint_q   <= hint_n;
            target_q <= target_n;
            att_q    <= att_n;
            win_q    <= win_n;
            lose_q   <= lose_n;
        end
    end

    always_comb begin
        fsm_n    = fsm;
        hint_n   = hint_q;
        target_n = target_q;
        att_n    = att_q;
        win_n    = win_q;
        lose_n   = lose_q;
        // Leaving the guess phase aborts the round and outranks any press.
        if (!state_s2) begin
            fsm_n  = S_IDLE;
            hint_n = HINT_NONE;
            att_n  = MAX_ATT;
            win_n  = 1'b0;
            lose_n = 1'b0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    target_n = W'(lfsr_val);
                    fsm_n    = S_GUESS;
                    hint_n   = HINT_NONE;
                    att_n    = MAX_ATT;
                    win_n    = 1'b0;
                    lose_n   = 1'b0;
                end
                S_GUESS: begin
                    if (press_pulse) begin
                        if (att_q != '0)
                            att_n = att_q - 1'b1;
                        if (guess == target_q) begin
                            hint_n = HINT_OK;
                            win_n  = 1'b1;
                            fsm_n  = S_WIN;
                        end else begin
                            hint_n = (guess < target_q) ? HINT_LOW : HINT_HIGH;
                            if (att_q <= 1) begin
                                lose_n = 1'b1;
                                fsm_n  = S_LOSE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign target        = target_q;
    assign hint          = hint_q;
    assign attempts_left = att_q;
    assign win           = win_q;
    assign lose          = lose_q;
    assign over          = win_q | lose_q;

endmodule

// File: tb/tb_guess_judge.sv
// Directed bench for guess_judge: a round-level behavioural model checked
// every cycle, plus hand-computed expectations at key points of each scenario.
module tb_guess_judge;

    localparam int         W    = 4;
    localparam int         MT   = 5;
    localparam logic [7:0] SEED = 8'hA5;

    logic         clk = 1'b0;
    logic         master_reset = 1'b0;
    logic         state = 1'b0;
    logic         submit = 1'b1;
    logic [W-1:0] guess = '0;
    logic [W-1:0] target;
    logic [1:0]   dut_hint;
    logic [3:0]   attempts_left;
    logic         win, lose, over;

    guess_judge #(.W(W), .MAX_TRIES(MT), .LFSR_SEED(SEED)) dut (
        .clk           (clk),
        .master_reset  (master_reset),
        .state         (state),
        .submit        (submit),
        .guess         (guess),
        .target        (target),
        .hint          (dut_hint),
        .attempts_left (attempts_left),
        .win           (win),
        .lose          (lose),
        .over          (over)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            if (errs <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Round model: phase 0 = waiting for guess phase, 1 = playing, 2 = decided.
    logic [7:0]   m_lfsr;
    logic [1:0]   m_st;
    logic [2:0]   m_sb;
    int           m_phase;
    logic [W-1:0] m_target;
    logic [1:0]   m_hint;
    int           m_att;
    logic         m_win, m_lose;

    always @(posedge clk) begin
        if (!master_reset) begin
            m_lfsr   <= SEED;
            m_st     <= 2'b00;
            m_sb     <= 3'b111;
            m_phase  <= 0;
            m_target <= '0;
            m_hint   <= 2'd0;
            m_att    <= MT;
            m_win    <= 1'b0;
            m_lose   <= 1'b0;
        end else begin
            m_lfsr <= lfsr_next(m_lfsr);
            m_st   <= {m_st[0], state};
            m_sb   <= {m_sb[1:0], submit};
            if (!m_st[1]) begin
                m_phase <= 0;
                m_hint  <= 2'd0;
                m_att   <= MT;
                m_win   <= 1'b0;
                m_lose  <= 1'b0;
            end else if (m_phase == 0) begin
                m_phase  <= 1;
                m_target <= m_lfsr[W-1:0];
            end else if (m_phase == 1 && m_sb[2] && !m_sb[1]) begin
                m_att <= m_att - 1;
                if (guess == m_target) begin
                    m_hint  <= 2'd3;
                    m_win   <= 1'b1;
                    m_phase <= 2;
                end else begin
                    m_hint <= (guess < m_target) ? 2'd1 : 2'd2;
                    if (m_att == 1) begin
                        m_lose  <= 1'b1;
                        m_phase <= 2;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m.target", int'(target), int'(m_target));
            chk("m.hint", int'(dut_hint), int'(m_hint));
            chk("m.attempts_left", int'(attempts_left), m_att);
            chk("m.win", int'(win), int'(m_win));
            chk("m.lose", int'(lose), int'(m_lose));
            chk("m.over", int'(over), int'(m_win | m_lose));
        end
    end

    // Raise state so the captured target's low bits equal want.
    task automatic start_round(input logic [W-1:0] want);
        logic [7:0] nxt;
        bit found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            nxt = lfsr_next(lfsr_next(m_lfsr));
            if (nxt[W-1:0] == want) begin
                state = 1'b1;
                found = 1;
            end
        end
        chk("round_start_found", int'(found), 1);
        repeat (3) @(negedge clk);
        chk("start.target", int'(target), int'(want));
        chk("start.attempts", int'(attempts_left), MT);
        chk("start.hint", int'(dut_hint), 0);
        chk("start.over", int'(over), 0);
    endtask

    task automatic press(input logic [W-1:0] g);
        @(negedge clk);
        guess  = g;
        submit = 1'b0;
        repeat (3) @(negedge clk);
        submit = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic end_round();
        @(negedge clk);
        state = 1'b0;
        repeat (3) @(negedge clk);
        chk("end.over", int'(over), 0);
        chk("end.attempts", int'(attempts_left), MT);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        master_reset = 1'b1;
        chk_en = 1'b1;
        chk("reset.target", int'(target), 0);
        chk("reset.attempts", int'(attempts_left), MT);
        chk("reset.hint", int'(dut_hint), 0);
        chk("reset.over", int'(over), 0);

        // Win round against target 9.
        start_round(4'd9);
        press(4'd3);
        chk("w1.hint", int'(dut_hint), 1);
        chk("w1.att", int'(attempts_left), 4);
        press(4'd12);
        chk("w2.hint", int'(dut_hint), 2);
        chk("w2.att", int'(attempts_left), 3);
        press(4'd9);
        chk("w3.hint", int'(dut_hint), 3);
        chk("w3.att", int'(attempts_left), 2);
        chk("w3.win", int'(win), 1);
        chk("w3.over", int'(over), 1);
        press(4'd5);
        chk("w4.hint", int'(dut_hint), 3);
        chk("w4.att", int'(attempts_left), 2);
        chk("w4.win", int'(win), 1);
        end_round();

        // Five wrong guesses exhaust the round.
        start_round(4'd4);
        for (int i = 0; i < MT; i++) press(4'd0);
        chk("l.lose", int'(lose), 1);
        chk("l.win", int'(win), 0);
        chk("l.over", int'(over), 1);
        chk("l.att", int'(attempts_left), 0);
        chk("l.hint", int'(dut_hint), 1);
        end_round();

        // Correct on the final attempt is a win.
        start_round(4'd7);
        for (int i = 0; i < MT - 1; i++) press(4'd15);
        chk("c4.att", int'(attempts_left), 1);
        chk("c4.hint", int'(dut_hint), 2);
        press(4'd7);
        chk("c5.win", int'(win), 1);
        chk("c5.lose", int'(lose), 0);
        chk("c5.att", int'(attempts_left), 0);
        end_round();

        // Long press gives exactly one judgement.
        start_round(4'd2);
        @(negedge clk);
        guess  = 4'd1;
        submit = 1'b0;
        repeat (20) @(negedge clk);
        submit = 1'b1;
        repeat (4) @(negedge clk);
        chk("hold.att", int'(attempts_left), 4);
        chk("hold.hint", int'(dut_hint), 1);
        end_round();

        // Press arriving together with the guess-phase entry is dropped.
        @(negedge clk);
        state  = 1'b1;
        submit = 1'b0;
        guess  = 4'd0;
        repeat (3) @(negedge clk);
        submit = 1'b1;
        repeat (4) @(negedge clk);
        chk("coinc.att", int'(attempts_left), MT);
        chk("coinc.hint", int'(dut_hint), 0);

        // Reset mid-round, then the LFSR restarts from the seed.
        for (int i = 0; i < 3; i++) press(m_target ^ 4'd1);
        chk("mid.att", int'(attempts_left), 2);
        @(negedge clk);
        master_reset = 1'b0;
        @(negedge clk);
        chk("mreset.target", int'(target), 0);
        chk("mreset.attempts", int'(attempts_left), MT);
        chk("mreset.hint", int'(dut_hint), 0);
        chk("mreset.over", int'(over), 0);
        master_reset = 1'b1;
        repeat (3) @(negedge clk);
        // Seed A5 -> 4A -> 95; the third edge captures 95.
        chk("reseed.target", int'(target), 5);
        end_round();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
